digit_entry: RTL

DIGIT_ENTRY -- requirements
Module: digit_entry

---
 rtl/digit_entry.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/digit_entry.sv
// Three-digit BCD keypad entry: synchronised, debounced buttons drive a small
// FSM that builds a right-aligned number and holds it until downstream accepts it.

module digit_debounce #(
    parameter int unsigned CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);
    localparam int unsigned CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          level_d_r;
    logic [CW-1:0] count_r;

    // Synchroniser, stable-run counter and accepted level with its one-cycle delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            count_r   <= '0;
        end else begin
            sync1_r   <= raw;
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            if (sync2_r != level_r) begin
                if (count_r == LAST) begin
                    level_r <= sync2_r;
                    count_r <= '0;
                end else begin
                    count_r <= count_r + CW'(1);
                end
            end else begin
                count_r <= '0;
            end
        end
    end

    // Only a fresh 0->1 of the accepted level is an action; release and hold do nothing.
    assign rise = level_r & ~level_d_r;
endmodule

module digit_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_digit,
    input  logic       key_press,
    input  logic       key_enter,
    input  logic       key_clear,
    input  logic       out_ready,
    output logic [3:0] x1,
    output logic [3:0] x2,
    output logic [3:0] x3,
    output logic       out_valid,
    output logic [1:0] digit_cnt,
    output logic       err
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    logic   press_rise;
    logic   enter_rise;
    logic   clear_rise;

    state_t     state_r;
    state_t     state_n;
    logic [3:0] x1_n;
    logic [3:0] x2_n;
    logic [3:0] x3_n;
    logic [1:0] cnt_n;
    logic       valid_n;
    logic       err_n;

    digit_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_press (
        .clk  (clk),
        .rst  (rst),
        .raw  (key_press),
        .rise (press_rise)
    );

    digit_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
        .clk  (clk),
        .rst  (rst),
        .raw  (key_enter),
        .rise (enter_rise)
    );

    digit_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
        .clk  (clk),
        .rst  (rst),
        .raw  (key_clear),
        .rise (clear_rise)
    );

    // State and all outputs are registered here; the comb block only computes next values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            x1        <= 4'd0;
            x2        <= 4'd0;
            x3        <= 4'd0;
            digit_cnt <= 2'd0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r   <= state_n;
            x1        <= x1_n;
            x2        <= x2_n;
            x3        <= x3_n;
            digit_cnt <= cnt_n;
            out_valid <= valid_n;
            err       <= err_n;
        end
    end

    // Action priority is clear > handshake/enter > digit; a losing action is simply dropped.
    always_comb begin
        state_n = state_r;
        x1_n    = x1;
        x2_n    = x2;
        x3_n    = x3;
        cnt_n   = digit_cnt;
        err_n   = 1'b0;
        if (clear_rise) begin
            state_n = IDLE;
            x1_n    = 4'd0;
            x2_n    = 4'd0;
            x3_n    = 4'd0;
            cnt_n   = 2'd0;
        end else begin
            case (state_r)
                IDLE, ENTRY: begin
                    if (enter_rise) begin
                        if (state_r == ENTRY) begin
                            state_n = HOLD;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (press_rise) begin
                        if ((key_digit > 4'd9) || (digit_cnt == 2'd3)) begin
                            err_n = 1'b1;
                        end else begin
                            x1_n    = x2;
                            x2_n    = x3;
                            x3_n    = key_digit;
                            cnt_n   = digit_cnt + 2'd1;
                            state_n = ENTRY;
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_n = IDLE;
                        x1_n    = 4'd0;
                        x2_n    = 4'd0;
                        x3_n    = 4'd0;
                        cnt_n   = 2'd0;
                    end else begin
                        state_n = HOLD;
                    end
                end
                default: begin
                    state_n = IDLE;
                    x1_n    = 4'd0;
                    x2_n    = 4'd0;
                    x3_n    = 4'd0;
                    cnt_n   = 2'd0;
                end
            endcase
        end
        valid_n = (state_n == HOLD);
    end
endmodule
